// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end sequencer: funct codes, FSM encoding
// and the divide-by-zero quotient.
package alu_pkg;

  localparam logic [11:0] FUNCT_ADD   = 12'h001;
  localparam logic [11:0] FUNCT_SUB   = 12'h002;
  localparam logic [11:0] FUNCT_MULLO = 12'h004;
  localparam logic [11:0] FUNCT_MULHI = 12'h008;
  localparam logic [11:0] FUNCT_DIV   = 12'h010;
  localparam logic [11:0] FUNCT_REM   = 12'h020;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational result/error selection for the ALU sequencer response channel.
module alu_result_mux
  import alu_pkg::*;
(
  input  logic [11:0] funct,
  input  logic [31:0] op_a,
  input  logic [31:0] add_c,
  input  logic [31:0] sub_c,
  input  logic [63:0] mul_out,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div0,
  input  logic        timeout,
  output logic [31:0] c,
  output logic        err
);

  always_comb begin
    c   = '0;
    err = 1'b0;
    if (timeout) begin
      err = 1'b1;
    end else begin
      case (funct)
        FUNCT_ADD:   c = add_c;
        FUNCT_SUB:   c = sub_c;
        FUNCT_MULLO: c = mul_out[31:0];
        FUNCT_MULHI: c = mul_out[63:32];
        FUNCT_DIV: begin
          c   = div0 ? DIV0_QUOTIENT : div_q;
          err = div0;
        end
        FUNCT_REM: begin
          c   = div0 ? op_a : div_r;
          err = div0;
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response front-end for the 32-bit ALU units.
// Optional wait-state timeout enabled by defining ALU_SEQUENCER_TIMEOUT_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] add_c,
  input  logic [31:0] sub_c,
  output logic        mul_start,
  input  logic [63:0] mul_out,
  input  logic        mul_ready,
  output logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_err
);

  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state, state_nx;
  logic [11:0] funct_q;
  logic        div0_q;
  logic        timeout_q;
  logic        mul_start_nx, div_start_nx;
  logic        timeout_hit;
  logic        expire;
  logic        accept;
  logic [31:0] mux_c;
  logic        mux_err;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef ALU_SEQUENCER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  // Expiry fires on the edge that brings the counter to TIMEOUT_CYCLES.
  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == ST_MUL_WAIT || state == ST_DIV_WAIT) && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    mul_start_nx = 1'b0;
    div_start_nx = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_funct)
            FUNCT_MULLO, FUNCT_MULHI: begin
              state_nx     = ST_MUL_WAIT;
              mul_start_nx = 1'b1;
            end
            FUNCT_DIV, FUNCT_REM: begin
              if (req_b == '0) begin
                state_nx = ST_DONE;
              end else begin
                state_nx     = ST_DIV_WAIT;
                div_start_nx = 1'b1;
              end
            end
            default: state_nx = ST_DONE;
          endcase
        end
      end
      // The start-pulse cycle still sees the previous op's held ready.
      ST_MUL_WAIT: begin
        if (mul_ready && !mul_start) begin
          state_nx = ST_DONE;
        end else if (expire) begin
          state_nx    = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DIV_WAIT: begin
        if (div_ready && !div_start) begin
          state_nx = ST_DONE;
        end else if (expire) begin
          state_nx    = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      funct_q   <= '0;
      div0_q    <= 1'b0;
      timeout_q <= 1'b0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
    end else begin
      state     <= state_nx;
      mul_start <= mul_start_nx;
      div_start <= div_start_nx;
      if (accept) begin
        op_a      <= req_a;
        op_b      <= req_b;
        funct_q   <= req_funct;
        div0_q    <= (req_b == '0);
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Units hold their outputs until restarted, so selecting live in DONE stays stable.
  alu_result_mux u_result_mux (
    .funct   (funct_q),
    .op_a    (op_a),
    .add_c   (add_c),
    .sub_c   (sub_c),
    .mul_out (mul_out),
    .div_q   (div_q),
    .div_r   (div_r),
    .div0    (div0_q),
    .timeout (timeout_q),
    .c       (mux_c),
    .err     (mux_err)
  );

  assign rsp_valid = (state == ST_DONE);
  assign rsp_c     = rsp_valid ? mux_c : '0;
  assign rsp_err   = rsp_valid && mux_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with behavioural adder/sub/mul/div unit models.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [11:0] req_funct;
  logic [31:0] req_a, req_b, op_a, op_b, add_c, sub_c;
  logic        mul_start, div_start;
  logic [63:0] mul_out = 64'hDEAD_BEEF_CAFE_F00D;
  logic        mul_ready = 1'b1;
  logic [31:0] div_q = 32'hBAD0_BAD0, div_r = 32'h0BAD_0BAD;
  logic        div_ready = 1'b1;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_c;

  int unsigned compared = 0, mismatched = 0;
  int unsigned mul_pulses = 0, div_pulses = 0, overlap = 0;
  int unsigned mul_lat = 33, div_lat = 10;
  bit          div_never = 1'b0;
  int unsigned mul_cnt = 0, div_cnt = 0;
  logic [63:0] mul_prod = '0;
  logic [31:0] div_qn = '0, div_rn = '0;

  always #5 clk = ~clk;

  alu_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .add_c(add_c), .sub_c(sub_c),
    .mul_start(mul_start), .mul_out(mul_out), .mul_ready(mul_ready),
    .div_start(div_start), .div_q(div_q), .div_r(div_r), .div_ready(div_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err)
  );

  assign add_c = op_a + op_b;
  assign sub_c = op_a - op_b;

  always @(posedge clk) begin
    if (mul_start) begin
      mul_ready <= 1'b0;
      mul_cnt   <= mul_lat;
      mul_prod  <= {32'b0, op_a} * {32'b0, op_b};
    end else if (!mul_ready && mul_cnt > 0) begin
      if (mul_cnt == 1) begin
        mul_ready <= 1'b1;
        mul_out   <= mul_prod;
      end
      mul_cnt <= mul_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (div_start) begin
      div_ready <= 1'b0;
      div_cnt   <= div_never ? 0 : div_lat;
      div_qn    <= (op_b != 0) ? op_a / op_b : 32'h0;
      div_rn    <= (op_b != 0) ? op_a % op_b : 32'h0;
    end else if (!div_ready && div_cnt > 0) begin
      if (div_cnt == 1) begin
        div_ready <= 1'b1;
        div_q     <= div_qn;
        div_r     <= div_rn;
      end
      div_cnt <= div_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (mul_start) mul_pulses <= mul_pulses + 1;
    if (div_start) div_pulses <= div_pulses + 1;
    if ((mul_start || div_start) && req_ready) overlap <= overlap + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned limit, output logic [31:0] c, output logic err,
                        output int unsigned lat, output bit got);
    req_funct = f;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    lat = 0;
    got = 1'b0;
    c   = '0;
    err = 1'b0;
    while (!got && lat < limit) begin
      tick();
      lat++;
      req_valid = 1'b0;
      if (rsp_valid) begin
        got = 1'b1;
        c   = rsp_c;
        err = rsp_err;
      end
    end
  endtask

  typedef struct {
    logic [11:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        err;
    int unsigned lat;
    int unsigned mp;
    int unsigned dp;
  } vec_t;

  localparam int unsigned NV = 14;
  vec_t vecs[NV];

  initial begin
    logic [31:0] c;
    logic        err;
    int unsigned lat, mp0, dp0, nvalid;
    bit          got;

    // lat 0 = not checked (multi-cycle units)
    vecs[0]  = '{FUNCT_ADD,   32'd5,         32'd7,         32'd12,          1'b0, 1, 0, 0};
    vecs[1]  = '{FUNCT_MULHI, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001,   1'b0, 0, 1, 0};
    vecs[2]  = '{FUNCT_DIV,   32'd100,       32'd7,         32'd14,          1'b0, 0, 0, 1};
    vecs[3]  = '{FUNCT_REM,   32'd100,       32'd7,         32'd2,           1'b0, 0, 0, 1};
    vecs[4]  = '{FUNCT_DIV,   32'd9,         32'd0,         32'hFFFF_FFFF,   1'b1, 1, 0, 0};
    vecs[5]  = '{FUNCT_REM,   32'd9,         32'd0,         32'd9,           1'b1, 1, 0, 0};
    vecs[6]  = '{FUNCT_MULLO, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001,   1'b0, 0, 1, 0};
    vecs[7]  = '{FUNCT_MULHI, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,   1'b0, 0, 1, 0};
    vecs[8]  = '{FUNCT_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE,   1'b0, 1, 0, 0};
    vecs[9]  = '{12'h040,     32'd1,         32'd2,         32'd0,           1'b1, 1, 0, 0};
    vecs[10] = '{12'h003,     32'd1,         32'd2,         32'd0,           1'b1, 1, 0, 0};
    vecs[11] = '{FUNCT_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,           1'b0, 1, 0, 0};
    vecs[12] = '{FUNCT_DIV,   32'd5,         32'd7,         32'd0,           1'b0, 0, 0, 1};
    vecs[13] = '{FUNCT_REM,   32'd5,         32'd7,         32'd5,           1'b0, 0, 0, 1};

    reset = 1'b0; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    check("reset_regs", {op_a, op_b, rsp_c}, '0);
    check("reset_flags", {rsp_valid, rsp_err, mul_start, div_start, req_ready}, 5'b00001);
    reset = 1'b1;
    tick();

    for (int unsigned i = 0; i < NV; i++) begin
      mp0 = mul_pulses;
      dp0 = div_pulses;
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 200, c, err, lat, got);
      check($sformatf("v%0d_rsp", i), got, 1'b1);
      check($sformatf("v%0d_c", i), c, vecs[i].c);
      check($sformatf("v%0d_err", i), err, vecs[i].err);
      if (vecs[i].lat != 0) check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      tick();
      check($sformatf("v%0d_idle", i), {req_ready, rsp_valid}, 2'b10);
      check($sformatf("v%0d_mulpulses", i), mul_pulses - mp0, vecs[i].mp);
      check($sformatf("v%0d_divpulses", i), div_pulses - dp0, vecs[i].dp);
    end

    // Response stall: result held, no new request taken.
    rsp_ready = 1'b0;
    run_op(FUNCT_SUB, 32'd3, 32'd5, 10, c, err, lat, got);
    check("stall_first", {got, c}, {1'b1, 32'hFFFF_FFFE});
    req_funct = FUNCT_ADD; req_a = 32'd100; req_b = 32'd100; req_valid = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check($sformatf("stall%0d_rsp", k), {rsp_valid, rsp_err, rsp_c}, {2'b10, 32'hFFFF_FFFE});
      check($sformatf("stall%0d_hold", k), {req_ready, op_a}, {1'b0, 32'd3});
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_release", {req_ready, rsp_valid}, 2'b10);
    tick();
    req_valid = 1'b0;
    check("stall_next", {rsp_valid, rsp_c}, {1'b1, 32'd200});
    tick();

    // Back-to-back add throughput: one response every other cycle.
    req_funct = FUNCT_ADD; req_a = 32'd2; req_b = 32'd3; req_valid = 1'b1;
    nvalid = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      if (rsp_valid && rsp_c == 32'd5) nvalid++;
    end
    req_valid = 1'b0;
    check("b2b_count", nvalid, 3);

    // Reset while waiting on the multiplier.
    mul_lat = 20;
    req_funct = FUNCT_MULLO; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    check("midrst_wait", {req_ready, rsp_valid}, 2'b00);
    reset = 1'b0;
    #1;
    check("midrst_regs", {op_a, op_b, rsp_c}, '0);
    check("midrst_flags", {rsp_valid, rsp_err, mul_start, div_start}, 4'b0000);
    tick(); tick();
    reset = 1'b1;
    nvalid = 0;
    for (int unsigned k = 0; k < 30; k++) begin
      tick();
      if (rsp_valid) nvalid++;
    end
    check("midrst_norsp", nvalid, 0);
    run_op(FUNCT_ADD, 32'd1, 32'd1, 10, c, err, lat, got);
    check("midrst_add", {got, err, c}, {2'b10, 32'd2});
    tick();

`ifdef ALU_SEQUENCER_TIMEOUT_EN
    div_never = 1'b1;
    run_op(FUNCT_DIV, 32'd8, 32'd2, 200, c, err, lat, got);
    check("timeout_rsp", {got, err, c}, {2'b11, 32'd0});
    check("timeout_lat", lat, 65);
    tick();
`endif

    check("start_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Front-end controller for the 32-bit ALU datapath.
- Accepts one operation at a time over a valid/ready request channel and drives a shared operand bus into the adder, subtractor, multi-cycle unsigned multiplier and unsigned divider.
- Start-pulses the multi-cycle units and waits for their ready, then selects and holds the result on a valid/ready response channel.
- Sits between the instruction decode/execute stage and the arithmetic units.

Parameters:
TIMEOUT_CYCLES, 64, wait-state cycle limit before aborting a multiply/divide (used only with the optional feature)
CNT_W, 7, width of the wait/timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_funct  input  12  operation code (package constants)
req_a  input  32  operand A
req_b  input  32  operand B
op_a  output  32  registered operand A to all units
op_b  output  32  registered operand B to all units
add_c  input  32  adder result
sub_c  input  32  subtractor result
mul_start  output  1  one-cycle multiply start pulse
mul_out  input  64  multiplier product
mul_ready  input  1  multiplier done, held until next start
div_start  output  1  one-cycle divide start pulse
div_q  input  32  quotient
div_r  input  32  remainder
div_ready  input  1  divider done, held until next start
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_c  output  32  result
rsp_err  output  1  illegal funct, divide-by-zero or timeout

Behaviour:
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Reset (reset=0, asynchronous): state=IDLE; op_a, op_b, rsp_c = 0; rsp_valid, rsp_err, mul_start, div_start = 0; counter=0.
  - Reset mid-operation abandons the operation; no response is produced.
- req_ready=1 only in IDLE. A request is accepted on req_valid && req_ready: op_a/op_b/funct are latched.
- op_a/op_b are held stable until the next accept.
- Funct codes:
  - ADD=12'h001, SUB=12'h002: next cycle go to DONE with rsp_c=add_c or sub_c, computed combinationally from the latched operands. Latency: rsp_valid 1 cycle after accept.
  - MULLO=12'h004, MULHI=12'h008: mul_start=1 for exactly the first cycle after accept; state=MUL_WAIT.
    - mul_ready is ignored in the start cycle.
    - On the first mul_ready=1 after the start cycle: rsp_c=mul_out[31:0] (MULLO) or mul_out[63:32] (MULHI); go to DONE.
  - DIV=12'h010, REM=12'h020: same pattern with div_start/div_ready; rsp_c=div_q or div_r.
  - Divide-by-zero (op_b==0): no div_start; DONE next cycle with rsp_err=1. rsp_c=32'hFFFF_FFFF (DIV) or op_a (REM).
  - Any other funct value: DONE next cycle with rsp_c=0, rsp_err=1.
- DONE: rsp_valid=1; rsp_c/rsp_err held stable until rsp_ready=1. On that cycle go to IDLE and clear rsp_valid.
  - Back-to-back throughput: one op every 2 cycles minimum for add/sub (accept, respond).
- Counter: clears on accept and increments each cycle in MUL_WAIT/DIV_WAIT. It saturates at 2^CNT_W-1.
- The start pulses never coincide with req_ready=1.

Optional Feature:
Macro: ALU_SEQUENCER_TIMEOUT_EN
- Defined: if counter reaches TIMEOUT_CYCLES in MUL_WAIT/DIV_WAIT without ready, go to DONE with rsp_c=0, rsp_err=1.
- If ready and expiry occur in the same cycle, ready wins and the result is normal.
- Not defined: waits indefinitely; the counter is unused and removed.

Decomposition:
- Package alu_pkg:
  - funct localparams (ADD, SUB, MULLO, MULHI, DIV, REM)
  - state enum encoding
  - DIV0_QUOTIENT constant 32'hFFFF_FFFF
- One natural sub-module, alu_result_mux: combinational selection of rsp_c/rsp_err from funct, unit outputs and the div-by-zero flag. The FSM and counter stay in alu_sequencer.

Test Plan:
- Reset release, ADD a=5 b=7, rsp_ready=1 -> rsp_valid exactly 1 cycle after accept; rsp_c=12, rsp_err=0; req_ready back to 1 the next cycle.
- MULHI a=32'hFFFF_FFFF b=2, model multiplier ready after 33 cycles, stale ready high during the start cycle -> single mul_start pulse; stale ready ignored; rsp_c=32'h0000_0001.
- DIV a=100 b=7 then REM a=100 b=7 -> rsp_c=14, then rsp_c=2; DIV a=9 b=0 -> no div_start, rsp_c=32'hFFFF_FFFF, rsp_err=1.
- SUB a=3 b=5 with rsp_ready low for 4 cycles -> rsp_c=32'hFFFF_FFFE held stable; req_ready=0 throughout; new req_valid not accepted.
- reset asserted in MUL_WAIT, then ADD 1+1 -> all outputs 0 during reset; no response for the multiply; next response rsp_c=2.
- With ALU_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=64, divider never ready -> rsp_valid at counter=64, rsp_c=0, rsp_err=1.
